// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_MU,
    GNT_TRIG
  } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_trigger_sync.sv
// Two-flop synchronizer for the external trigger level, followed by a change detector.
module trigger_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic level,
  output logic change
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= trigger;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level  = sync2;
  assign change = sync2 ^ prev;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback, multi-cycle results and the trigger mirror.
// Define STARVE_GUARD_EN to enable the starvation counter that stalls writeback for low-priority writers.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int TRIG_REG   = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall_req,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              mu_valid,
  input  logic [ADDR_W-1:0] mu_rd,
  input  logic [DATA_W-1:0] mu_data,
  output logic              mu_ready,
  input  logic              trigger,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd
);

  if (STARVE_MAX < 1) begin : g_starve_max_check
    $error("STARVE_MAX must be at least 1");
  end
  if ((1 << ADDR_W) != NUM_REGS) begin : g_addr_w_check
    $error("ADDR_W must index exactly NUM_REGS registers");
  end

  logic [NUM_REGS-1:0] busy;
  logic                trig_level, trig_change;
  logic                trig_pend, trig_val;
  grant_t              gnt;

  trigger_sync u_trigger_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .trigger(trigger),
    .level  (trig_level),
    .change (trig_change)
  );

  // A requested stall demotes writeback below both low-priority writers for that cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (wb_we && !wb_stall_req) gnt = GNT_WB;
    else if (mu_valid)          gnt = GNT_MU;
    else if (trig_pend)         gnt = GNT_TRIG;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wd    = '0;
    mu_ready = 1'b0;
    unique case (gnt)
      GNT_WB: begin
        rf_we   = (wb_addr != '0);
        rf_addr = wb_addr;
        rf_wd   = wb_data;
      end
      GNT_MU: begin
        rf_we    = (mu_rd != '0);
        rf_addr  = mu_rd;
        rf_wd    = mu_data;
        mu_ready = 1'b1;
      end
      GNT_TRIG: begin
        rf_we   = 1'b1;
        rf_addr = ADDR_W'(TRIG_REG);
        rf_wd   = {{(DATA_W-1){1'b0}}, trig_val};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (gnt == GNT_MU) busy[mu_rd] <= 1'b0;
      if (iss_valid && iss_ready && iss_rd != '0) busy[iss_rd] <= 1'b1;
    end
  end

  assign iss_ready = !busy[iss_rd];
  assign rs1_busy  = (rs1_addr != '0) && busy[rs1_addr];
  assign rs2_busy  = (rs2_addr != '0) && busy[rs2_addr];

  // A new level always wins over a same-cycle grant so the latest value is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_pend <= 1'b0;
      trig_val  <= 1'b0;
    end else if (trig_change) begin
      trig_pend <= 1'b1;
      trig_val  <= trig_level;
    end else if (gnt == GNT_TRIG) begin
      trig_pend <= 1'b0;
    end
  end

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt, starve_cnt_n;

  always_comb begin
    starve_cnt_n = starve_cnt;
    if (wb_stall_req || gnt == GNT_MU || gnt == GNT_TRIG)
      starve_cnt_n = '0;
    else if (gnt == GNT_WB && (mu_valid || trig_pend) && starve_cnt != CNT_W'(STARVE_MAX))
      starve_cnt_n = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt   <= '0;
      wb_stall_req <= 1'b0;
    end else begin
      starve_cnt   <= starve_cnt_n;
      wb_stall_req <= !wb_stall_req && (starve_cnt_n == CNT_W'(STARVE_MAX));
    end
  end
`else
  assign wb_stall_req = 1'b0;
`endif

  a_no_wb_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_we && wb_stall_req));
  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_we && busy[wb_addr]));
  a_mu_dest_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(mu_valid && !busy[mu_rd] && mu_rd != '0));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural reference model.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int TRIG_REG   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall_req;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic        iss_ready;
  logic        mu_valid = 1'b0;
  logic [4:0]  mu_rd = '0;
  logic [31:0] mu_data = '0;
  logic        mu_ready;
  logic        trigger = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall_req(wb_stall_req),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .mu_valid(mu_valid), .mu_rd(mu_rd), .mu_data(mu_data), .mu_ready(mu_ready),
    .trigger(trigger), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mu_valid;
    logic [4:0]  mu_rd;
    logic [31:0] mu_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } in_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        mu_rdy;
    logic        iss_rdy;
    logic        rs1b;
    logic        rs2b;
    logic        stall;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
    bit    wd_care;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: which registers await a multi-cycle result, the pending trigger
  // mirror, the history of sampled trigger levels and the consecutive-lost-cycle count.
  bit m_busy[32];
  bit m_pend = 1'b0;
  bit m_val = 1'b0;
  bit m_stall = 1'b0;
  int m_lost = 0;
  bit samp[$];

  function automatic in_t mkIn(bit we, logic [4:0] wa, logic [31:0] wd, bit mv, logic [4:0] mr,
                               logic [31:0] md, bit iv, logic [4:0] ir, logic [4:0] r1, logic [4:0] r2);
    in_t s;
    s.wb_we = we; s.wb_addr = wa; s.wb_data = wd;
    s.mu_valid = mv; s.mu_rd = mr; s.mu_data = md;
    s.iss_valid = iv; s.iss_rd = ir; s.rs1 = r1; s.rs2 = r2;
    return s;
  endfunction

  function automatic out_t mkOut(bit we, logic [4:0] a, logic [31:0] d, bit mr, bit ir,
                                 bit r1, bit r2, bit st);
    out_t o;
    o.we = we; o.addr = a; o.wd = d; o.mu_rdy = mr; o.iss_rdy = ir;
    o.rs1b = r1; o.rs2b = r2; o.stall = st;
    return o;
  endfunction

  task automatic applyStimulus(input in_t s);
    wb_we = s.wb_we; wb_addr = s.wb_addr; wb_data = s.wb_data;
    mu_valid = s.mu_valid; mu_rd = s.mu_rd; mu_data = s.mu_data;
    iss_valid = s.iss_valid; iss_rd = s.iss_rd;
    rs1_addr = s.rs1; rs2_addr = s.rs2;
  endtask

  task automatic checkOutput(input string name, input out_t exp, input bit wd_care);
    out_t act, m;
    act = {rf_we, rf_addr, rf_wd, mu_ready, iss_ready, rs1_busy, rs2_busy, wb_stall_req};
    m = '1;
    if (!wd_care) m.wd = '0;
    vectors++;
    if (((act ^ exp) & m) !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got we=%0b addr=%0d wd=%h mu_ready=%0b iss_ready=%0b rs1_busy=%0b rs2_busy=%0b stall=%0b; expected we=%0b addr=%0d wd=%h%s mu_ready=%0b iss_ready=%0b rs1_busy=%0b rs2_busy=%0b stall=%0b",
               name, $time, act.we, act.addr, act.wd, act.mu_rdy, act.iss_rdy, act.rs1b, act.rs2b, act.stall,
               exp.we, exp.addr, exp.wd, wd_care ? "" : "(ignored)", exp.mu_rdy, exp.iss_rdy,
               exp.rs1b, exp.rs2b, exp.stall);
    end
  endtask

  task automatic step(input string name, input in_t s, input out_t e, input bit wd_care);
    @(negedge clk);
    applyStimulus(s);
    #1;
    checkOutput(name, e, wd_care);
  endtask

  // Expected outputs from the priority rules applied to the model state and current inputs.
  function automatic out_t expOut(output bit wd_care);
    out_t e = '0;
    wd_care = 1'b1;
    e.iss_rdy = !m_busy[iss_rd];
    e.rs1b    = m_busy[rs1_addr];
    e.rs2b    = m_busy[rs2_addr];
    e.stall   = m_stall;
    if (wb_we && !m_stall) begin
      e.we = (wb_addr != 0); e.addr = wb_addr; e.wd = wb_data; wd_care = (wb_addr != 0);
    end else if (mu_valid) begin
      e.mu_rdy = 1'b1; e.we = (mu_rd != 0); e.addr = mu_rd; e.wd = mu_data; wd_care = (mu_rd != 0);
    end else if (m_pend) begin
      e.we = 1'b1; e.addr = 5'(TRIG_REG); e.wd = {31'b0, m_val};
    end
    return e;
  endfunction

  task automatic modelReset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_pend = 1'b0; m_val = 1'b0; m_stall = 1'b0; m_lost = 0;
    samp.delete();
  endtask

  task automatic modelStep();
    bit gwb, gmu, gtrig, accept, pend_now, lvl, old;
    int n;
    pend_now = m_pend;
    gwb    = wb_we && !m_stall;
    gmu    = !gwb && mu_valid;
    gtrig  = !gwb && !mu_valid && pend_now;
    accept = iss_valid && !m_busy[iss_rd];
    if (gmu) m_busy[mu_rd] = 1'b0;
    if (accept && iss_rd != 0) m_busy[iss_rd] = 1'b1;
`ifdef STARVE_GUARD_EN
    if (m_stall) begin
      m_stall = 1'b0; m_lost = 0;
    end else if (gmu || gtrig) begin
      m_lost = 0;
    end else if (gwb && (mu_valid || pend_now)) begin
      m_lost++;
      if (m_lost == STARVE_MAX) begin
        m_stall = 1'b1; m_lost = 0;
      end
    end
`endif
    // The synchronized level lags the sampled input by two edges; compare with one edge older.
    n   = samp.size();
    lvl = (n >= 2) ? samp[n-2] : 1'b0;
    old = (n >= 3) ? samp[n-3] : 1'b0;
    if (lvl != old) begin
      m_pend = 1'b1; m_val = lvl;
    end else if (gtrig) begin
      m_pend = 1'b0;
    end
    samp.push_back(trigger);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) modelReset();
    else modelStep();
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[8];
    in_t  idle;
    out_t zero_out;
    out_t e;
    bit   wdc, found;
    int   lat;

    idle     = '0;
    zero_out = mkOut(0, 0, 0, 0, 1, 0, 0, 0);

    tbl[0] = '{"idle",        mkIn(0, 0, 0, 0, 0, 0, 0, 3, 0, 0),                     zero_out, 1'b1};
    tbl[1] = '{"wb_x5",       mkIn(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0),          mkOut(1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 0), 1'b1};
    tbl[2] = '{"wb_x31",      mkIn(1, 31, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 31, 0),        mkOut(1, 31, 32'hA5A5A5A5, 0, 1, 0, 0, 0), 1'b1};
    tbl[3] = '{"wb_x0",       mkIn(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0),          mkOut(0, 0, 0, 0, 1, 0, 0, 0), 1'b0};
    tbl[4] = '{"mu_x0",       mkIn(0, 0, 0, 1, 0, 32'hCAFE, 0, 0, 0, 0),              mkOut(0, 0, 0, 1, 1, 0, 0, 0), 1'b0};
    tbl[5] = '{"wb_beats_mu", mkIn(1, 7, 32'h11, 1, 0, 32'h22, 0, 0, 0, 0),           mkOut(1, 7, 32'h11, 0, 1, 0, 0, 0), 1'b1};
    tbl[6] = '{"mu_x0_again", mkIn(0, 0, 0, 1, 0, 32'h33, 0, 0, 0, 0),                mkOut(0, 0, 0, 1, 1, 0, 0, 0), 1'b0};
    tbl[7] = '{"idle_end",    mkIn(0, 0, 0, 0, 0, 0, 0, 31, 0, 31),                   zero_out, 1'b1};

    applyStimulus(idle);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("in_reset", zero_out, 1'b1);
    rst_n = 1'b1;
    step("after_reset", idle, zero_out, 1'b1);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) step(tbl[i].name, tbl[i].stim, tbl[i].exp, tbl[i].wd_care);

    $display("[TB] issue to x9 and multi-cycle completion");
    step("iss_x9",      mkIn(0, 0, 0, 0, 0, 0, 1, 9, 9, 0),        mkOut(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step("x9_busy",     mkIn(0, 0, 0, 0, 0, 0, 0, 9, 9, 0),        mkOut(0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
    step("mu_x9",       mkIn(0, 0, 0, 1, 9, 32'h1234, 0, 9, 9, 0), mkOut(1, 9, 32'h1234, 1, 0, 1, 0, 0), 1'b1);
    step("x9_released", mkIn(0, 0, 0, 0, 0, 0, 0, 9, 9, 0),        mkOut(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);

    $display("[TB] register x0 writers");
    step("iss_x0",   mkIn(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),       mkOut(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    step("mu_x0_rf", mkIn(0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0),  mkOut(0, 0, 0, 1, 1, 0, 0, 0), 1'b0);
    step("wb_x0_rf", mkIn(1, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0),  mkOut(0, 0, 0, 0, 1, 0, 0, 0), 1'b0);

    $display("[TB] writeback starving a multi-cycle result");
    step("iss_x10", mkIn(0, 0, 0, 0, 0, 0, 1, 10, 0, 10), mkOut(0, 0, 0, 0, 1, 0, 0, 0), 1'b1);
    for (int i = 0; i < STARVE_MAX; i++)
      step("starve_wb_wins", mkIn(1, 5, 32'h0BAD0000 + i, 1, 10, 32'hABCD, 0, 0, 0, 10),
           mkOut(1, 5, 32'h0BAD0000 + i, 0, 1, 0, 1, 0), 1'b1);
`ifdef STARVE_GUARD_EN
    step("starve_stall", mkIn(0, 0, 0, 1, 10, 32'hABCD, 0, 0, 0, 10), mkOut(1, 10, 32'hABCD, 1, 1, 0, 1, 1), 1'b1);
`else
    for (int i = 0; i < STARVE_MAX; i++)
      step("no_guard_wb_wins", mkIn(1, 5, 32'h0BAD1000 + i, 1, 10, 32'hABCD, 0, 0, 0, 10),
           mkOut(1, 5, 32'h0BAD1000 + i, 0, 1, 0, 1, 0), 1'b1);
    step("no_guard_mu", mkIn(0, 0, 0, 1, 10, 32'hABCD, 0, 0, 0, 10), mkOut(1, 10, 32'hABCD, 1, 1, 0, 1, 0), 1'b1);
`endif
    step("starve_done", mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 10), zero_out, 1'b1);

    $display("[TB] trigger rise and fall");
    @(negedge clk);
    applyStimulus(idle);
    trigger = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6 && !found; k++) begin
      @(negedge clk);
      #1;
      if (rf_we === 1'b1 && rf_addr === 5'(TRIG_REG)) begin
        found = 1'b1;
        lat = k;
      end
    end
    vectors++;
    if (!found || lat < 2 || lat > 3) begin
      miscompares++;
      $display("[TB] FAIL trig_rise_latency: got %0d cycles (seen=%0b), expected 2..3", lat, found);
    end
    if (found) checkOutput("trig_rise_write", mkOut(1, 6, 32'h1, 0, 1, 0, 0, 0), 1'b1);
    trigger = 1'b0;
    for (int i = 0; i < 4; i++)
      step("trig_fall_wb", mkIn(1, 5, 32'h5555, 0, 0, 0, 0, 0, 0, 0), mkOut(1, 5, 32'h5555, 0, 1, 0, 0, 0), 1'b1);
    step("trig_fall_write", idle, mkOut(1, 6, 32'h0, 0, 1, 0, 0, 0), 1'b1);
    step("trig_consumed", idle, zero_out, 1'b1);

    $display("[TB] reset in the middle of traffic");
    trigger = 1'b1;
    step("rst_mid_issue", mkIn(1, 5, 32'h600D, 0, 0, 0, 1, 9, 0, 0), mkOut(1, 5, 32'h600D, 0, 1, 0, 0, 0), 1'b1);
    for (int i = 0; i < 3; i++)
      step("rst_mid_wb", mkIn(1, 5, 32'h600D, 0, 0, 0, 0, 0, 9, 0), mkOut(1, 5, 32'h600D, 0, 1, 1, 0, 0), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    trigger = 1'b0;
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 9, 0));
    #1;
    checkOutput("rst_mid_assert", zero_out, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step("post_reset_quiet", mkIn(0, 0, 0, 0, 0, 0, 0, 9, 9, 0), zero_out, 1'b1);

    $display("[TB] randomized traffic against reference model");
    for (int c = 0; c < 400; c++) begin
      logic [4:0] r;
      @(negedge clk);
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      wb_we    = ($urandom_range(0, 2) != 0) && !m_stall && !m_busy[wb_addr];
      r        = 5'($urandom_range(0, 7));
      mu_rd    = r;
      mu_data  = $urandom;
      mu_valid = (m_busy[r] || r == 0) && ($urandom_range(0, 1) == 1);
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd   = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) trigger = ~trigger;
      #1;
      e = expOut(wdc);
      checkOutput("random", e, wdc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
